// File: rtl/rle_pkg.sv
// Shared RLE types: default widths, run-pair record and expander state encoding.
// Also used by the rle_compressor testbenches.
package rle_pkg;

  localparam int RLE_PIX_W = 8;
  localparam int RLE_CNT_W = 8;

  typedef struct packed {
    logic [RLE_PIX_W-1:0] pix;
    logic [RLE_CNT_W-1:0] count;
    logic                 last;
  } rle_pair_t;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } rle_state_t;

endpackage

// File: rtl/rle_pair_fifo.sv
// Synchronous first-word-fall-through FIFO for run pairs, with flush.
// A write while full is accepted only when a read happens on the same edge.
module rle_pair_fifo #(
  parameter int DATA_W = 17,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic              wr_ok_s;
  logic              rd_ok_s;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign rd_ok_s = rd_en && !empty;
  assign wr_ok_s = wr_en && (!full || rd_ok_s);
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage array, write port only.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/rle_decompressor.sv
// RLE run-pair expander: FIFO-buffered (pixel, count) pairs re-expanded into a ready/valid pixel stream.
// Optional build macro RLE_DECOMP_STATS_EN enables the pix_total/run_total frame counters.
module rle_decompressor
  import rle_pkg::*;
#(
  parameter int PIX_W      = RLE_PIX_W,
  parameter int CNT_W      = RLE_CNT_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PIX_W-1:0] run_data_in,
  input  logic [CNT_W-1:0] run_count_in,
  input  logic             run_valid_in,
  input  logic             run_last_in,
  output logic [PIX_W-1:0] pixel_out,
  output logic             pixel_valid,
  input  logic             pixel_ready,
  output logic             done,
  output logic             overflow,
  output logic             zero_run,
  output logic [15:0]      pix_total,
  output logic [15:0]      run_total
);

  localparam int PAIR_W = PIX_W + CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  rle_state_t        state_r, state_nxt_s;
  logic [PIX_W-1:0]  run_pix_r;
  logic [CNT_W-1:0]  remain_r;
  logic              run_last_r;
  logic              zlast_r;
  logic              done_r, overflow_r, zero_run_r;

  logic [PAIR_W-1:0] fifo_wdata_s, fifo_rdata_s;
  logic              fifo_full_s, fifo_empty_s;
  logic              hs_s, run_end_s, pop_s, push_s, drop_s, zero_in_s, nz_in_s;
  logic              done_s, start_s;

  assign fifo_wdata_s = {run_data_in, run_count_in, run_last_in};

  rle_pair_fifo #(
    .DATA_W (PAIR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (done_s),
    .wr_en   (push_s),
    .wr_data (fifo_wdata_s),
    .rd_en   (pop_s),
    .rd_data (fifo_rdata_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Handshake, FIFO control and end-of-frame detection.
  always_comb begin
    start_s   = (state_r == IDLE) && start;
    hs_s      = (remain_r != CNT_ZERO) && pixel_ready;
    run_end_s = hs_s && (remain_r == CNT_ONE);
    nz_in_s   = (state_r == EXPAND) && run_valid_in && (run_count_in != CNT_ZERO);
    zero_in_s = (state_r == EXPAND) && run_valid_in && (run_count_in == CNT_ZERO);
    // A finishing last run never pulls a following pair: the frame is over.
    pop_s     = (state_r == EXPAND) && !fifo_empty_s &&
                ((remain_r == CNT_ZERO) || (run_end_s && !run_last_r));
    push_s    = nz_in_s && (!fifo_full_s || pop_s);
    drop_s    = nz_in_s && fifo_full_s && !pop_s;
    // A zero-count last pair ends the frame once everything ahead of it is out.
    done_s    = (state_r == EXPAND) &&
                ((run_end_s && run_last_r) ||
                 (zlast_r && fifo_empty_s && ((remain_r == CNT_ZERO) || run_end_s)));
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = EXPAND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXPAND: begin
        if (done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = EXPAND;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, run register, done pulse and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      run_pix_r  <= {PIX_W{1'b0}};
      remain_r   <= CNT_ZERO;
      run_last_r <= 1'b0;
      zlast_r    <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
      zero_run_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= done_s;
      if (pop_s) begin
        {run_pix_r, remain_r, run_last_r} <= fifo_rdata_s;
      end else if (hs_s) begin
        remain_r <= remain_r - CNT_ONE;
      end
      if (start_s) begin
        overflow_r <= 1'b0;
        zero_run_r <= 1'b0;
        zlast_r    <= 1'b0;
      end else begin
        if (drop_s) begin
          overflow_r <= 1'b1;
        end
        if (zero_in_s) begin
          zero_run_r <= 1'b1;
        end
        if (done_s) begin
          zlast_r <= 1'b0;
        end else if (zero_in_s && run_last_in) begin
          zlast_r <= 1'b1;
        end
      end
    end
  end

  assign pixel_out   = run_pix_r;
  assign pixel_valid = (remain_r != CNT_ZERO);
  assign done        = done_r;
  assign overflow    = overflow_r;
  assign zero_run    = zero_run_r;

`ifdef RLE_DECOMP_STATS_EN
  logic [15:0] pix_total_r, run_total_r;

  // Per-frame statistics, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst || start_s) begin
      pix_total_r <= 16'd0;
      run_total_r <= 16'd0;
    end else begin
      if (hs_s) begin
        pix_total_r <= pix_total_r + 16'd1;
      end
      if (pop_s) begin
        run_total_r <= run_total_r + 16'd1;
      end
    end
  end

  assign pix_total = pix_total_r;
  assign run_total = run_total_r;
`else
  assign pix_total = 16'd0;
  assign run_total = 16'd0;
`endif

endmodule

// File: tb/tb_rle_decompressor.sv
// Directed self-checking bench for rle_decompressor.
// Stats expectations follow the RLE_DECOMP_STATS_EN build macro.
module tb_rle_decompressor;
  import rle_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, run_valid_in, run_last_in, pixel_ready;
  logic [7:0]  run_data_in, run_count_in;
  logic [7:0]  pixel_out;
  logic        pixel_valid, done, overflow, zero_run;
  logic [15:0] pix_total, run_total;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  got_q[$];
  int          hs_cyc_q[$];
  int          done_cnt;
  int          done_at_size;
  int          cyc;
  logic        stall_prev;
  logic [7:0]  stall_pix;

  always #5 clk = ~clk;

  rle_decompressor dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .run_data_in  (run_data_in),
    .run_count_in (run_count_in),
    .run_valid_in (run_valid_in),
    .run_last_in  (run_last_in),
    .pixel_out    (pixel_out),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .done         (done),
    .overflow     (overflow),
    .zero_run     (zero_run),
    .pix_total    (pix_total),
    .run_total    (run_total)
  );

  // Advance one cycle; outputs are observed on the falling edge, inputs change 1ns after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if ({pixel_valid, pixel_out} !== {1'b1, stall_pix}) begin
          errors++;
          $display("FAIL stall_hold: valid=%b pixel=%h, required valid=1 pixel=%h", pixel_valid, pixel_out, stall_pix);
        end
      end
      if (pixel_valid && pixel_ready) begin
        got_q.push_back(pixel_out);
        hs_cyc_q.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_at_size = got_q.size();
      end
      stall_prev = pixel_valid && !pixel_ready;
      stall_pix  = pixel_out;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; run_valid_in = 1'b0; run_last_in = 1'b0;
    run_data_in = 8'h00; run_count_in = 8'h00; pixel_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    got_q.delete(); hs_cyc_q.delete();
    done_cnt = 0; done_at_size = -1;
  endtask

  task automatic send(input logic [7:0] p, input logic [7:0] c, input logic l);
    run_data_in = p; run_count_in = c; run_last_in = l; run_valid_in = 1'b1;
    tick();
    run_valid_in = 1'b0; run_last_in = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (done_cnt == 0 && n < max_cyc) begin
      tick();
      n++;
    end
    tick(); tick(); tick();
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL done_pulse: saw %0d done pulses, required 1", done_cnt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pixel_valid, done, overflow, zero_run, pix_total, run_total, pixel_out} !== 44'd0) begin
      errors++;
      $display("FAIL reset_outputs: v=%b d=%b o=%b z=%b pt=%0d rt=%0d px=%h, required all 0",
               pixel_valid, done, overflow, zero_run, pix_total, run_total, pixel_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_a[4];
    int exp_pt, exp_rt;
    exp_a = '{8'h10, 8'h10, 8'h10, 8'h20};
`ifdef RLE_DECOMP_STATS_EN
    exp_pt = 4; exp_rt = 2;
`else
    exp_pt = 0; exp_rt = 0;
`endif
    do_start();
    pixel_ready = 1'b1;
    send(8'h10, 8'd3, 1'b0);
    send(8'h20, 8'd1, 1'b1);
    wait_done(20);
    checks++;
    if (got_q.size() !== 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d pixels, required 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_a[i]) begin
        errors++;
        $display("FAIL b2b_pixel[%0d]: got %h, required %h", i, got_q[i], exp_a[i]);
      end
    end
    if (hs_cyc_q.size() == 4) begin
      checks++;
      if (hs_cyc_q[3] - hs_cyc_q[0] !== 3) begin
        errors++;
        $display("FAIL b2b_gapless: 4 pixels spanned %0d cycles, required 3", hs_cyc_q[3] - hs_cyc_q[0]);
      end
    end
    checks++;
    if (done_at_size !== 4) begin
      errors++;
      $display("FAIL b2b_done_timing: done after %0d pixels, required 4", done_at_size);
    end
    checks++;
    if (pix_total !== 16'(exp_pt) || run_total !== 16'(exp_rt)) begin
      errors++;
      $display("FAIL b2b_stats: pix_total=%0d run_total=%0d, required %0d %0d", pix_total, run_total, exp_pt, exp_rt);
    end
    checks++;
    if (dut.state_r !== IDLE || pixel_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: state=%0d valid=%b, required IDLE and 0", dut.state_r, pixel_valid);
    end
  endtask

  task automatic test_long_run_stall();
    int bad = 0;
    int n = 0;
    do_start();
    pixel_ready = 1'b1;
    send(8'hAA, 8'd255, 1'b1);
    while (done_cnt == 0 && n < 1000) begin
      pixel_ready = ~pixel_ready;
      tick();
      n++;
    end
    pixel_ready = 1'b1;
    tick(); tick(); tick();
    foreach (got_q[i]) if (got_q[i] !== 8'hAA) bad++;
    checks++;
    if (got_q.size() !== 255 || bad !== 0) begin
      errors++;
      $display("FAIL long_run: %0d pixels (%0d not AA), required 255 of AA", got_q.size(), bad);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL long_run_done: %0d done pulses, required 1", done_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_a[13];
    int exp_rt;
    exp_a = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h03, 8'h04, 8'h04,
              8'h05, 8'h05, 8'h05, 8'h05, 8'h07};
`ifdef RLE_DECOMP_STATS_EN
    exp_rt = 6;
`else
    exp_rt = 0;
`endif
    do_start();
    pixel_ready = 1'b0;
    send(8'h01, 8'd2, 1'b0);
    send(8'h02, 8'd3, 1'b0);
    send(8'h03, 8'd1, 1'b0);
    send(8'h04, 8'd2, 1'b0);
    send(8'h05, 8'd4, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early: overflow=%b with run reg + 4 FIFO entries, required 0", overflow);
    end
    send(8'h06, 8'd5, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: overflow=%b after pair into full FIFO, required 1", overflow);
    end
    pixel_ready = 1'b1;
    repeat (20) tick();
    send(8'h07, 8'd1, 1'b1);
    wait_done(20);
    checks++;
    if (got_q.size() !== 13) begin
      errors++;
      $display("FAIL ovf_count: %0d pixels replayed, required 13", got_q.size());
    end
    for (int i = 0; i < 13 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_a[i]) begin
        errors++;
        $display("FAIL ovf_pixel[%0d]: got %h, required %h", i, got_q[i], exp_a[i]);
      end
    end
    checks++;
    if (run_total !== 16'(exp_rt) || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: run_total=%0d overflow=%b, required %0d and 1", run_total, overflow, exp_rt);
    end
  endtask

  task automatic test_zero_run();
    do_start();
    checks++;
    if (overflow !== 1'b0 || zero_run !== 1'b0) begin
      errors++;
      $display("FAIL start_clears: overflow=%b zero_run=%b, required 0 0", overflow, zero_run);
    end
    pixel_ready = 1'b1;
    send(8'h55, 8'd0, 1'b0);
    checks++;
    if (zero_run !== 1'b1) begin
      errors++;
      $display("FAIL zero_run_set: zero_run=%b, required 1", zero_run);
    end
    send(8'h66, 8'd2, 1'b1);
    wait_done(20);
    checks++;
    if (got_q.size() !== 2 || got_q[0] !== 8'h66 || got_q[1] !== 8'h66) begin
      errors++;
      $display("FAIL zero_run_out: %0d pixels first=%h, required 2 of 66", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
    do_start();
    pixel_ready = 1'b1;
    send(8'h77, 8'd3, 1'b0);
    send(8'h00, 8'd0, 1'b1);
    wait_done(20);
    checks++;
    if (got_q.size() !== 3 || done_at_size !== 3) begin
      errors++;
      $display("FAIL zero_last: %0d pixels, done after %0d, required 3 and 3", got_q.size(), done_at_size);
    end
  endtask

  task automatic test_reset_mid_run();
    int n = 0;
    do_start();
    send(8'h11, 8'd0, 1'b0);
    pixel_ready = 1'b1;
    send(8'h99, 8'd200, 1'b1);
    while (got_q.size() < 100 && n < 300) begin
      tick();
      n++;
    end
    rst = 1'b1;
    pixel_ready = 1'b0;
    checks++;
    if (dut.remain_r !== 8'd100 || zero_run !== 1'b1) begin
      errors++;
      $display("FAIL midrun_setup: remaining=%0d zero_run=%b, required 100 and 1", dut.remain_r, zero_run);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (pixel_valid !== 1'b0 || dut.state_r !== IDLE || zero_run !== 1'b0 ||
        overflow !== 1'b0 || done !== 1'b0 || pix_total !== 16'd0 || dut.remain_r !== 8'd0) begin
      errors++;
      $display("FAIL midrun_reset: valid=%b state=%0d zr=%b ovf=%b done=%b pt=%0d rem=%0d, required all 0/IDLE",
               pixel_valid, dut.state_r, zero_run, overflow, done, pix_total, dut.remain_r);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] exp_q[$];
    logic [7:0] val, prev;
    int len;
    int bad = 0;
    prev = 8'h00;
    do_start();
    pixel_ready = 1'b1;
    for (int r = 0; r < 40; r++) begin
      len = $urandom_range(1, 10);
      do val = 8'($urandom_range(0, 255)); while (val == prev);
      prev = val;
      repeat (len) exp_q.push_back(val);
      send(val, 8'(len), r == 39);
      repeat (len - 1) tick();
    end
    wait_done(100);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL loop_count: %0d pixels, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad !== 0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL loop_data: %0d pixel differences, overflow=%b, required 0 and 0", bad, overflow);
    end
  endtask

  initial begin
    cyc = 0; done_cnt = 0; done_at_size = -1; stall_prev = 1'b0; stall_pix = 8'h00;
    test_reset();
    test_back_to_back();
    test_long_run_stall();
    test_overflow();
    test_zero_run();
    test_reset_mid_run();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
